// File: rtl/counter_pkg.sv
// Shared definitions for the saturating up/down counter pair: state encoding,
// default window constants and the load clamp helper.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_HI = 4'b1100;
  localparam logic [CNT_WIDTH-1:0] CNT_LO = 4'b0011;

  // Clamp a requested start value into [lo, hi]; widths are fixed at 32 bits
  // so the same helper serves any counter width up to that.
  function automatic logic [31:0] clamp(input logic [31:0] val,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    logic [31:0] r;
    r = val;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable saturating down-counter with start/busy/done handshake.
// Define DOWN_COUNTER_WRAP_EN to make RUN free-run LO->HI with a done pulse per wrap.
module down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH,
  parameter logic [WIDTH-1:0] HI = WIDTH'(CNT_HI),
  parameter logic [WIDTH-1:0] LO = WIDTH'(CNT_LO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t state;
  logic [31:0] load_val;

  assign load_val = clamp(32'(start_val), 32'(LO), 32'(HI));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= HI;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= load_val[WIDTH-1:0];
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            if (count > LO) begin
              count <= count - 1'b1;
            end else begin
`ifdef DOWN_COUNTER_WRAP_EN
              // done doubles as the registered wrap flag; state stays in RUN
              count <= HI;
              done  <= 1'b1;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter; the wrap-mode scenario runs when
// DOWN_COUNTER_WRAP_EN is defined, the saturating scenarios otherwise.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_val;
  logic       en;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  int tog_en [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int tog_cnt[8] = '{6, 5, 5, 4, 4, 3, 3, 3};
  int tog_dn [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  down_counter #(.WIDTH(4), .HI(4'd12), .LO(4'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_val(start_val),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int b, input int d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_val = 4'd0; en = 1'b0; abort = 1'b0;
    tick();
    check_all("reset", 12, 0, 0);

    // reset dominates start
    start = 1'b1; start_val = 4'd5; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("rst_hold", 12, 0, 0);
    end
    rst = 1'b0; start = 1'b0; en = 1'b0;
    tick();
    check_all("idle", 12, 0, 0);

`ifndef DOWN_COUNTER_WRAP_EN
    // full countdown from 12
    start = 1'b1; start_val = 4'd12; en = 1'b1;
    tick();
    start = 1'b0;
    check_all("full_load", 12, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_all("full_run", 12 - i, 1, 0);
    end
    tick();
    check_all("full_done", 3, 1, 1);
    tick();
    check_all("full_idle", 3, 0, 0);

    // clamp high, then abort right away
    start = 1'b1; start_val = 4'd15; en = 1'b0;
    tick();
    start = 1'b0;
    check_all("clamp_hi", 12, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("clamp_hi_abort", 12, 0, 0);

    // clamp low: done two cycles after start
    start = 1'b1; start_val = 4'd1; en = 1'b1;
    tick();
    start = 1'b0;
    check_all("clamp_lo", 3, 1, 0);
    tick();
    check_all("clamp_lo_done", 3, 1, 1);
    tick();
    check_all("clamp_lo_idle", 3, 0, 0);

    // new start accepted on first idle cycle; en toggling, mid-run start ignored
    start = 1'b1; start_val = 4'd6; en = 1'b0;
    tick();
    start = 1'b0;
    check_all("tog_load", 6, 1, 0);
    for (int i = 0; i < 8; i++) begin
      en = tog_en[i][0];
      start = (i == 2);
      start_val = 4'd12;
      tick();
      check_all("tog_run", tog_cnt[i], 1, tog_dn[i]);
    end
    start = 1'b0; en = 1'b0;
    tick();
    check_all("tog_idle", 3, 0, 0);

    // abort at count 8 wins over en
    start = 1'b1; start_val = 4'd10; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_all("abort_pre", 8, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("abort", 8, 0, 0);
    tick();
    check_all("abort_hold", 8, 0, 0);

    // reset mid-run at count 5
    start = 1'b1; start_val = 4'd9; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_all("rst_mid_pre", 5, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check_all("rst_mid", 12, 0, 0);
    tick();
    check_all("rst_mid_idle", 12, 0, 0);
`else
    // free-running wrap mode
    start = 1'b1; start_val = 4'd4; en = 1'b1;
    tick();
    start = 1'b0;
    check_all("wrap_load", 4, 1, 0);
    tick();
    check_all("wrap_lo", 3, 1, 0);
    tick();
    check_all("wrap_1", 12, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_all("wrap_run", 12 - i, 1, 0);
    end
    tick();
    check_all("wrap_2", 12, 1, 1);
    tick();
    check_all("wrap_after", 11, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("wrap_abort", 11, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable, saturating down-counter with a start/busy/done handshake. It counts from a requested start value down to a fixed floor, then reports completion. It is the complement of the team's saturating up-counter, which resets to 3 and climbs to 12. This block walks the same 3..12 window in the other direction and is used as the countdown/timeout side of that counter pair.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- HI, 12, ceiling of the count window and reset value of `count`
- LO, 3, floor of the count window; must satisfy LO < HI < 2**WIDTH

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a countdown; sampled only in IDLE
- start_val  input  WIDTH  initial count, sampled with `start`
- en  input  1  count enable; one decrement per enabled cycle
- abort  input  1  cancels a run; sampled in RUN only
- count  output  WIDTH  current count, registered
- busy  output  1  high whenever the state is not IDLE, registered
- done  output  1  one-cycle completion pulse, registered

## Operation
- States: IDLE, RUN, DONE. One-hot or binary encoding is allowed; only the behaviour is fixed.
- Reset (`rst`=1 at a clock edge): state = IDLE, `count` = HI, `busy` = 0, `done` = 0. Reset overrides every other input and applies in any state, including mid-run.
- IDLE:
  - `start`=1 loads `count` with `start_val` clamped into [LO, HI]: a value above HI loads HI, a value below LO loads LO.
  - The state then moves to RUN.
  - `en` and `abort` are ignored in IDLE. `count` holds its value.
- RUN:
  - Priority order is abort, then en.
  - `abort`=1: go to IDLE, `count` holds, no `done` pulse.
  - `en`=1 and `count` > LO: `count` <= `count` − 1.
  - `en`=1 and `count` == LO: go to DONE, `count` holds at LO.
  - `en`=0: hold.
  - `start` is ignored in RUN.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE. `start` and `abort` are ignored in DONE.
- `busy` = 1 in RUN and DONE. `done` = 1 only in DONE.
- Arithmetic: a plain WIDTH-bit subtract, guarded by the `count` > LO compare, so `count` never leaves [LO, HI] and never underflows.

## Timing
- `start` at edge N: `count` = clamped value and `busy` = 1 after edge N+1.
- With `en` held high, a start value of S (after clamping) gives:
  - `count` reaches LO S−LO cycles after the load.
  - One further cycle later, `done` = 1.
  - Total from the `start` edge to the `done` pulse: S−LO+2 cycles.
- `done` is high for exactly 1 cycle. `busy` falls on the same edge that `done` falls.
- Start at the floor (clamped value == LO) with `en` high: `done` comes 2 cycles after `start`.
- A new `start` is accepted on the first cycle back in IDLE, i.e. the cycle after `done`.
- `abort` at edge N: `busy` = 0 after edge N+1, and `count` is frozen at its value from edge N.

## Configuration
- Macro: `DOWN_COUNTER_WRAP_EN`.
- Undefined (default): saturating behaviour exactly as specified above.
- Defined: in RUN, `en`=1 with `count` == LO behaves as follows:
  - `count` <= HI.
  - `done` pulses for 1 cycle; it is driven directly from a registered wrap flag.
  - The state remains RUN, so the block free-runs LO→HI→…→LO until `abort` or `rst`.
  - The DONE state is unreachable in this mode.
  - `busy` stays high until `abort` or `rst`.

## Structure
- Shared package `counter_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants CNT_WIDTH=4, CNT_HI=4'b1100, CNT_LO=4'b0011, also used by the up-counter;
  - a clamp helper function, min/max into [LO, HI].
- No sub-module: the load clamp is the helper function, and the counter and FSM are a single always block each.

## Test plan
- Reset → `count`=12, `busy`=0, `done`=0; hold `rst` high for 3 cycles with `start`=1 → no change.
- `start`=1 with `start_val`=12, `en`=1 throughout → `count` runs 12,11,…,3; `done` pulses 11 cycles after `start`; `busy` is high for 11 cycles.
- Clamping:
  - `start_val`=15 → `count` loads 12.
  - `start_val`=1 → `count` loads 3, and `done` pulses 2 cycles after `start`.
- `start_val`=6 with `en` toggling every other cycle → `count` 6,6,5,5,4,4,3; `done` pulses once; `start` pulsed mid-run is ignored.
- Abort and reset mid-run:
  - `abort` with `count`=8 → IDLE, `count` stays 8, no `done`.
  - `rst` mid-run with `count`=5 → `count`=12 and IDLE on the next edge.
- With `DOWN_COUNTER_WRAP_EN` defined, `start_val`=4, `en`=1 → `count` 4,3,12,11,…; `done` pulses each time 3→12; `busy` stays high until `abort`.
